mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage: 2-entry skid buffer between memory stage and register-file writeback.
//  Selects writeback data (ALU result or memory load) at capture.
//  Valid/ready handshake on both sides; hazard stall and flush.
//  Exports forwarding info from its youngest entry for the EX-stage bypass network.
// PARAMETERS
//  DATA_W       16  width of ALU result, memory data and writeback data
//  REG_ADDR_W   4   destination-register index width
//  R0_HARDWIRED 1   1: capture of rd==0 forces reg_write=0; 0: R0 is writable
//  CNT_W        16  stall-counter width (MEMWB_PERF_CNT_EN builds only)
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high
//  hazard         in   1           freeze: no accept, no emit
//  flush          in   1           discard all entries
//  in_valid       in   1           MEM side offers an entry
//  in_ready       out  1           stage can accept
//  in_alu_result  in   DATA_W      ALU result
//  in_mem_data    in   DATA_W      load data
//  in_rd          in   REG_ADDR_W  destination register
//  in_reg_write   in   1           entry writes the register file
//  in_mem_to_reg  in   1           1: wb_data=in_mem_data; 0: in_alu_result
//  out_valid      out  1           head entry presented to WB
//  out_ready      in   1           WB consumes the head
//  out_wb_data    out  DATA_W      head writeback data
//  out_rd         out  REG_ADDR_W  head destination
//  out_reg_write  out  1           head write enable (RF write = out_valid & out_ready & out_reg_write)
//  fwd_valid      out  1           youngest entry is valid and has reg_write=1
//  fwd_rd         out  REG_ADDR_W  youngest entry destination
//  fwd_data       out  DATA_W      youngest entry writeback data
//  stall_count    out  CNT_W       present only with MEMWB_PERF_CNT_EN
// BEHAVIOUR
//  - Storage: head and skid entries {wb_data, rd, reg_write}; state EMPTY(0) / ONE(1) / FULL(2).
//  - in_ready  = (state != FULL) & ~hazard. out_valid = (state != EMPTY) & ~hazard.
//  - accept = in_valid & in_ready; emit = out_valid & out_ready.
//  - Capture: wb_data = in_mem_to_reg ? in_mem_data : in_alu_result.
//    reg_write = in_reg_write & ~(R0_HARDWIRED & (in_rd == 0)).
//  - Latency: accepted entry appears at out_* on the next cycle (1 cycle); no combinational in->out path.
//  - Transitions:
//    EMPTY + accept -> ONE (head=new).
//    ONE + accept, no emit -> FULL (skid=new).
//    ONE + emit, no accept -> EMPTY.
//    ONE + accept + emit -> ONE (head=new).
//    FULL + emit -> ONE (head=skid).
//    FULL never accepts.
//  - hazard=1: state and all entries hold; in_ready=out_valid=0.
//  - flush=1: next state EMPTY. An accept in the same cycle is discarded. Flush overrides hazard.
//  - Youngest entry: skid if FULL, head if ONE. fwd_* are all 0 when EMPTY. fwd_* ignore hazard.
//  - Reset (synchronous, active-high): state EMPTY; out_wb_data, out_rd, out_reg_write, fwd_* and stall_count all 0.
//    Reset wins over flush and hazard.
//  - out_* data fields are 0 whenever state is EMPTY; entries are zeroed on emit-to-empty.
// CONFIGURATION
//  MEMWB_PERF_CNT_EN defined:
//   - stall_count increments when (state != EMPTY) & (hazard | ~out_ready).
//   - Saturates at all-ones; cleared by reset only, not by flush.
//  MEMWB_PERF_CNT_EN undefined:
//   - stall_count port and counter logic are absent; all other behaviour is identical.
// TESTING (DATA_W=16, REG_ADDR_W=4, R0_HARDWIRED=1)
//  1. Reset=1 for 2 cycles with inputs nonzero -> out_valid=0, in_ready=1, out_wb_data=0, fwd_valid=0.
//  2. Load path: accept {alu=16'h1EDF, mem=16'h7EF3, rd=5, rw=1, m2r=1}, out_ready=1
//     -> next cycle out_valid=1, out_wb_data=16'h7EF3, out_rd=5, fwd_valid=1, fwd_rd=5.
//     With m2r=0 -> out_wb_data=16'h1EDF.
//  3. Backpressure: out_ready=0, push A(rd=1) then B(rd=2) -> FULL, in_ready=0, head=A, fwd_rd=2.
//     Raise out_ready -> A emitted, then B, then out_valid=0.
//  4. Hazard: in FULL assert hazard 3 cycles -> out_valid=0, in_ready=0, entries unchanged.
//     Deassert -> A then B emitted in order. With MEMWB_PERF_CNT_EN, stall_count advances by 3.
//  5. Flush in ONE with in_valid=1 -> next cycle EMPTY, out_valid=0, fwd_valid=0; incoming entry lost.
//  6. R0: accept {rd=0, rw=1, alu=16'hFFFF, m2r=0} -> out_valid=1, out_reg_write=0, fwd_valid=0.
//     Emit + accept same cycle in ONE -> state stays ONE with the new head.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: 2-entry MEM/WB skid buffer (wb select, hazard/flush, youngest-entry forwarding); MEMWB_PERF_CNT_EN adds stall_count
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_ADDR_W = 4,
  parameter int R0_HARDWIRED = 1
`ifdef MEMWB_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_wb_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
`ifdef MEMWB_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_count,
`endif
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] head_data, skid_data, cap_data;
  logic [REG_ADDR_W-1:0] head_rd, skid_rd;
  logic head_rw, skid_rw, cap_rw, accept, emit;
  assign in_ready = state != FULL && !hazard;
  assign out_valid = state != EMPTY && !hazard;
  assign accept = in_valid && in_ready;
  assign emit = out_valid && out_ready;
  assign cap_data = in_mem_to_reg ? in_mem_data : in_alu_result;
  assign cap_rw = in_reg_write && !(R0_HARDWIRED != 0 && in_rd == '0);
  assign out_wb_data = head_data;
  assign out_rd = head_rd;
  assign out_reg_write = head_rw;
  assign fwd_valid = state == FULL ? skid_rw : head_rw;
  assign fwd_rd = state == FULL ? skid_rd : head_rd;
  assign fwd_data = state == FULL ? skid_data : head_data;
  always_comb begin
    state_n = state;
    state_n = flush ? EMPTY :
              state == EMPTY ? (accept ? ONE : EMPTY) :
              state == ONE ? (accept && !emit ? FULL : emit && !accept ? EMPTY : ONE) :
              (emit ? ONE : FULL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      {head_data, head_rd, head_rw, skid_data, skid_rd, skid_rw} <= '0;
    end else begin
      state <= state_n;
      if (state_n == EMPTY)
        {head_data, head_rd, head_rw, skid_data, skid_rd, skid_rw} <= '0;
      else if (state == EMPTY || (state == ONE && accept && emit))
        {head_data, head_rd, head_rw} <= {cap_data, in_rd, cap_rw};
      else if (state == ONE && accept)
        {skid_data, skid_rd, skid_rw} <= {cap_data, in_rd, cap_rw};
      else if (state == FULL && emit) begin
        {head_data, head_rd, head_rw} <= {skid_data, skid_rd, skid_rw};
        {skid_data, skid_rd, skid_rw} <= '0;
      end
    end
  end
`ifdef MEMWB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) stall_count <= '0;
    else if (state != EMPTY && (hazard || !out_ready) && stall_count != '1) stall_count <= stall_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table plus randomized run against a queue model of mem_wb_stage
module tb_mem_wb_stage;
  logic clk = 0, reset, hazard, flush, in_valid, in_ready, in_reg_write, in_mem_to_reg;
  logic out_valid, out_ready, out_reg_write, fwd_valid;
  logic [15:0] in_alu_result, in_mem_data, out_wb_data, fwd_data;
  logic [3:0] in_rd, out_rd, fwd_rd;
`ifdef MEMWB_PERF_CNT_EN
  logic [15:0] stall_count;
  int unsigned cnt_m;
`endif
  int total = 0, pass = 0;
  always #5 clk = ~clk;
  mem_wb_stage dut (
    .clk(clk), .reset(reset), .hazard(hazard), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_data(out_wb_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
`ifdef MEMWB_PERF_CNT_EN
    .stall_count(stall_count),
`endif
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );
  typedef struct {
    logic r, h, f, v;
    logic [15:0] alu, mem;
    logic [3:0] rd;
    logic rw, m2r, ordy;
    logic [43:0] exp;
  } vec_t;
  typedef struct {
    logic [15:0] data;
    logic [3:0] rd;
    logic rw;
  } ent_t;
  vec_t tbl[21];
  ent_t q[$];
  function automatic vec_t mk(logic r, h, f, v, logic [15:0] alu, mem, logic [3:0] rd, logic rw, m2r, ordy,
                              logic ov, ir, logic [15:0] wb, logic [3:0] ord, logic orw, fv, logic [3:0] frd, logic [15:0] fd);
    vec_t t;
    t = '{r, h, f, v, alu, mem, rd, rw, m2r, ordy, {ov, ir, wb, ord, orw, fv, frd, fd}};
    return t;
  endfunction
  function automatic logic [43:0] act();
    return {out_valid, in_ready, out_wb_data, out_rd, out_reg_write, fwd_valid, fwd_rd, fwd_data};
  endfunction
  task automatic drive(vec_t t);
    {reset, hazard, flush, in_valid} = {t.r, t.h, t.f, t.v};
    {in_alu_result, in_mem_data, in_rd} = {t.alu, t.mem, t.rd};
    {in_reg_write, in_mem_to_reg, out_ready} = {t.rw, t.m2r, t.ordy};
  endtask
  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s act=%h exp=%h", name, a, e);
  endtask
  initial begin
    tbl[0]  = mk(1,0,0,1, 16'h1234,16'h5678,3,1,1,1, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[1]  = mk(1,0,0,1, 16'h1234,16'h5678,3,1,1,1, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[2]  = mk(0,0,0,1, 16'h1EDF,16'h7EF3,5,1,1,1, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[3]  = mk(0,0,0,1, 16'h1EDF,16'h7EF3,6,1,0,1, 1,1,16'h7EF3,5,1,1,5,16'h7EF3);
    tbl[4]  = mk(0,0,0,0, 16'h0,16'h0,0,0,0,1, 1,1,16'h1EDF,6,1,1,6,16'h1EDF);
    tbl[5]  = mk(0,0,0,1, 16'h00A1,16'h0,1,1,0,0, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[6]  = mk(0,0,0,1, 16'h00B2,16'h0,2,1,0,0, 1,1,16'h00A1,1,1,1,1,16'h00A1);
    tbl[7]  = mk(0,1,0,1, 16'h00C3,16'h0,3,1,0,1, 0,0,16'h00A1,1,1,1,2,16'h00B2);
    tbl[8]  = mk(0,1,0,1, 16'h00C3,16'h0,3,1,0,1, 0,0,16'h00A1,1,1,1,2,16'h00B2);
    tbl[9]  = mk(0,1,0,1, 16'h00C3,16'h0,3,1,0,1, 0,0,16'h00A1,1,1,1,2,16'h00B2);
    tbl[10] = mk(0,0,0,0, 16'h0,16'h0,0,0,0,1, 1,0,16'h00A1,1,1,1,2,16'h00B2);
    tbl[11] = mk(0,0,0,0, 16'h0,16'h0,0,0,0,1, 1,1,16'h00B2,2,1,1,2,16'h00B2);
    tbl[12] = mk(0,0,0,0, 16'h0,16'h0,0,0,0,1, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[13] = mk(0,0,0,1, 16'h0D0D,16'h0,7,1,0,0, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[14] = mk(0,0,1,1, 16'h0E0E,16'h0,8,1,0,0, 1,1,16'h0D0D,7,1,1,7,16'h0D0D);
    tbl[15] = mk(0,0,0,1, 16'hFFFF,16'h0,0,1,0,0, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[16] = mk(0,0,0,1, 16'h0123,16'h4567,9,1,1,1, 1,1,16'hFFFF,0,0,0,0,16'hFFFF);
    tbl[17] = mk(0,1,1,0, 16'h0,16'h0,0,0,0,1, 0,0,16'h4567,9,1,1,9,16'h4567);
    tbl[18] = mk(0,0,0,1, 16'h0055,16'h0,4,1,0,0, 0,1,16'h0,0,0,0,0,16'h0);
    tbl[19] = mk(1,1,1,1, 16'h0066,16'h0,5,1,0,0, 0,0,16'h0055,4,1,1,4,16'h0055);
    tbl[20] = mk(0,0,0,0, 16'h0,16'h0,0,0,0,1, 0,1,16'h0,0,0,0,0,16'h0);
    drive(tbl[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), 64'(act()), 64'(tbl[i].exp));
      @(posedge clk); #1;
    end
    reset = 1;
    @(posedge clk); #1;
    q.delete();
`ifdef MEMWB_PERF_CNT_EN
    cnt_m = 0;
`endif
    for (int c = 0; c < 400; c++) begin
      ent_t hd, yg;
      logic [43:0] e;
      int sz;
      reset = $urandom_range(63) == 0;
      hazard = $urandom_range(5) == 0;
      flush = $urandom_range(15) == 0;
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      in_alu_result = 16'($urandom);
      in_mem_data = 16'($urandom);
      in_rd = 4'($urandom);
      in_reg_write = 1'($urandom);
      in_mem_to_reg = 1'($urandom);
      #1;
      sz = q.size();
      hd = sz > 0 ? q[0] : '{16'h0, 4'h0, 1'b0};
      yg = sz > 0 ? q[sz-1] : '{16'h0, 4'h0, 1'b0};
      e = {sz > 0 && !hazard, sz < 2 && !hazard, hd.data, hd.rd, hd.rw, yg.rw, yg.rd, yg.data};
      chk($sformatf("rand%0d", c), 64'(act()), 64'(e));
`ifdef MEMWB_PERF_CNT_EN
      chk($sformatf("cnt%0d", c), 64'(stall_count), 64'(cnt_m));
      if (reset) cnt_m = 0;
      else if (sz > 0 && (hazard || !out_ready) && cnt_m < 65535) cnt_m++;
`endif
      if (reset || flush) q.delete();
      else begin
        if (sz > 0 && !hazard && out_ready) void'(q.pop_front());
        if (sz < 2 && !hazard && in_valid)
          q.push_back('{in_mem_to_reg ? in_mem_data : in_alu_result, in_rd, in_reg_write && in_rd != 0});
      end
      @(posedge clk); #1;
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
